// File: rtl/sophon_pkg.sv
// Shared SOPHON types: LSU request/ack structs used by the ITCM arbiter,
// plus the external-channel bridge state enum, queue entry and window defaults.
package sophon_pkg;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  typedef struct packed {
    logic        ack;
    logic        error;
    logic [31:0] rdata;
  } lsu_ack_t;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_REQ  = 2'd1,
    BR_GAP  = 2'd2
  } itcm_br_state_e;

  localparam logic [31:0] ITCM_BASE_ADDR  = 32'h8000_0000;
  localparam logic [31:0] ITCM_SIZE_BYTES = 32'h0001_0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  strb;
  } itcm_br_entry_t;

  // Wrapping subtraction makes addresses below the base land far above size.
  function automatic logic in_itcm_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] size);
    logic [31:0] offset;
    offset = addr - base;
    return (offset < size);
  endfunction

endpackage

// File: rtl/itcm_ext_req_fifo.sv
// Generic DEPTH-entry request FIFO with wrap-bit pointers; head is read
// combinationally. A push while full is accepted when a pop happens the same cycle.
module itcm_ext_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 69
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) begin
      return {~p[AW], {AW{1'b0}}};
    end
    return {p[AW], p[AW-1:0] + AW'(1)};
  endfunction

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                   (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/itcm_ext_bridge.sv
// Feeds the ITCM arbiter's external channel from a queued system-side
// valid/ready port, with window check, ack timeout and a one-entry response slot.
module itcm_ext_bridge
  import sophon_pkg::*;
#(
  parameter int unsigned REQ_DEPTH = 2,
  parameter logic [31:0] ITCM_BASE = ITCM_BASE_ADDR,
  parameter logic [31:0] ITCM_SIZE = ITCM_SIZE_BYTES,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  // Valid/ready channels: a beat transfers on the rising edge where valid and
  // ready are both high; valid and payload hold until then, ready never waits on valid.
  input  logic           s_req_valid_i,
  output logic           s_req_ready_o,
  input  logic [31:0]    s_req_addr_i,
  input  logic [31:0]    s_req_wdata_i,
  input  logic           s_req_we_i,
  input  logic [3:0]     s_req_strb_i,
  output logic           s_rsp_valid_o,
  input  logic           s_rsp_ready_i,
  output logic [31:0]    s_rsp_rdata_o,
  output logic           s_rsp_error_o,
  output lsu_req_t       ext_itcm_req_o,
  input  lsu_ack_t       ext_itcm_ack_i,
  output logic           busy_o,
  output itcm_br_state_e dbg_state_o
);

  localparam int unsigned CW = $clog2(TIMEOUT);

  itcm_br_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           oor_pend_q;
  lsu_req_t       req_q;
  logic           rsp_valid_q;
  logic [31:0]    rsp_rdata_q;
  logic           rsp_error_q;

  itcm_br_entry_t push_entry;
  itcm_br_entry_t head;
  logic           fifo_full;
  logic           fifo_empty;
  logic           push;
  logic           pop;
  logic           launch;
  logic           oor_set;
  logic           rsp_load;
  logic [31:0]    rsp_rdata_d;
  logic           rsp_error_d;
  logic           head_in_range;
  logic           can_launch;

  assign push_entry = '{addr: s_req_addr_i, wdata: s_req_wdata_i,
                        we: s_req_we_i, strb: s_req_strb_i};
  assign push       = s_req_valid_i & s_req_ready_o;

  itcm_ext_req_fifo #(
    .DEPTH (REQ_DEPTH),
    .WIDTH ($bits(itcm_br_entry_t))
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (push_entry),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_in_range = in_itcm_window(head.addr, ITCM_BASE, ITCM_SIZE);
  // A pending out-of-range error owns the slot for the GAP cycle, so nothing launches then.
  assign can_launch    = ~fifo_empty & (~rsp_valid_q | s_rsp_ready_i) & ~oor_pend_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pop         = 1'b0;
    launch      = 1'b0;
    oor_set     = 1'b0;
    rsp_load    = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = '0;
    case (state_q)
      BR_REQ: begin
        if (ext_itcm_ack_i.ack) begin
          rsp_load    = 1'b1;
          rsp_error_d = ext_itcm_ack_i.error;
          rsp_rdata_d = (req_q.we || ext_itcm_ack_i.error) ? '0 : ext_itcm_ack_i.rdata;
          state_d     = BR_GAP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rsp_load    = 1'b1;
          rsp_error_d = 1'b1;
          state_d     = BR_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        // IDLE and GAP share launch logic; GAP keeps req low for one cycle.
        if (oor_pend_q) begin
          rsp_load    = 1'b1;
          rsp_error_d = 1'b1;
          state_d     = BR_IDLE;
        end else if (can_launch) begin
          pop = 1'b1;
          if (head_in_range) begin
            launch  = 1'b1;
            cnt_d   = '0;
            state_d = BR_REQ;
          end else begin
            oor_set = 1'b1;
            state_d = BR_GAP;
          end
        end else begin
          state_d = BR_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= BR_IDLE;
      cnt_q       <= '0;
      oor_pend_q  <= 1'b0;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      oor_pend_q <= oor_set;
      req_q.req  <= (state_d == BR_REQ);
      if (launch) begin
        req_q.addr  <= head.addr;
        req_q.wdata <= head.wdata;
        req_q.we    <= head.we;
        req_q.be    <= head.strb;
      end
      if (rsp_load) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= rsp_rdata_d;
        rsp_error_q <= rsp_error_d;
      end else if (rsp_valid_q && s_rsp_ready_i) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign s_req_ready_o  = ~fifo_full;
  assign s_rsp_valid_o  = rsp_valid_q;
  assign s_rsp_rdata_o  = rsp_rdata_q;
  assign s_rsp_error_o  = rsp_error_q;
  assign ext_itcm_req_o = req_q;
  assign busy_o         = ~fifo_empty | (state_q != BR_IDLE);
  assign dbg_state_o    = state_q;

endmodule
